// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter for the shared RAM bus (m0 = ifetch, m1 = data).
// The grant is held for a whole transfer. A watchdog aborts transfers when the slave stalls too long.
module mips_bus_arbiter #(
   parameter int MAX_WAIT = 255,
   parameter int WAIT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic [31:0] s_address,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   output logic        s_read,
   output logic        s_write,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   output logic [1:0]  owner,
   output logic        timeout_err
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] BUS0 = 2'b01;
   localparam logic [1:0] BUS1 = 2'b10;

   logic [1:0]        state;
   logic              last_served;
   logic [WAIT_W-1:0] wait_cnt;
   logic              req0, req1, busy, own_req, other_req, abort, done;

   assign req0      = m0_read | m0_write;
   assign req1      = m1_read | m1_write;
   assign busy      = (state == BUS0) | (state == BUS1);
   assign own_req   = (state == BUS0) ? req0 : (state == BUS1) ? req1 : 1'b0;
   assign other_req = (state == BUS0) ? req1 : req0;
   assign abort     = busy & own_req & s_waitrequest & (wait_cnt == WAIT_W'(MAX_WAIT));
   assign done      = busy & own_req & ~s_waitrequest;
   assign owner     = state;

   // Slave side follows the owner combinationally so an async reset drops strobes at once.
   always_comb begin
      s_address      = '0;
      s_writedata    = '0;
      s_byteenable   = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m0_readdata    = '0;
      m1_readdata    = '0;
      case (state)
         BUS0: begin
            s_address      = m0_address;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            s_write        = m0_write & ~abort;
            s_read         = m0_read & ~m0_write & ~abort;
            m0_waitrequest = s_waitrequest & ~abort;
            m0_readdata    = abort ? '0 : s_readdata;
         end
         BUS1: begin
            s_address      = m1_address;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            s_write        = m1_write & ~abort;
            s_read         = m1_read & ~m1_write & ~abort;
            m1_waitrequest = s_waitrequest & ~abort;
            m1_readdata    = abort ? '0 : s_readdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last_served <= 1'b1;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (req0 & (~req1 | last_served)) state <= BUS0;
               else if (req1)                    state <= BUS1;
            end
            BUS0, BUS1: begin
               // Completion hands straight to a waiting peer; drop or abort always go idle.
               if (!own_req || done || abort) begin
                  last_served <= (state == BUS1);
                  wait_cnt    <= '0;
                  state       <= (done && other_req) ? ((state == BUS0) ? BUS1 : BUS0) : IDLE;
                  if (abort) timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: immediate-assertion checks plus a per-master
// completion scoreboard (expected data queued at drive time, popped on completion).
module tb_mips_bus_arbiter;
   logic        clk, reset;
   logic [31:0] m0_address, m0_writedata, m0_readdata, m1_address, m1_writedata, m1_readdata;
   logic        m0_read, m0_write, m0_waitrequest, m1_read, m1_write, m1_waitrequest;
   logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
   logic [31:0] s_address, s_writedata, s_readdata;
   logic        s_read, s_write, s_waitrequest, timeout_err;
   logic [1:0]  owner;

   typedef struct { logic wr; logic [31:0] data; } sb_t;
   sb_t q0[$], q1[$];
   int  errors = 0, checks = 0;

   mips_bus_arbiter #(.MAX_WAIT(4), .WAIT_W(8)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
      .s_readdata(s_readdata), .owner(owner), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running required done");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input bit m, input logic wr, input logic [31:0] d);
      sb_t e;
      e.wr = wr;
      e.data = d;
      if (m) q1.push_back(e); else q0.push_back(e);
   endtask

   task automatic sb_check();
      sb_t e;
      if (owner == 2'b01 && !m0_waitrequest) begin
         chk("sb_m0_expected", (q0.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("sb_m0_data", e.wr ? s_writedata : m0_readdata, e.data);
         end
      end
      if (owner == 2'b10 && !m1_waitrequest) begin
         chk("sb_m1_expected", (q1.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("sb_m1_data", e.wr ? s_writedata : m1_readdata, e.data);
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
      s_waitrequest = 1'b0; s_readdata = '0;
      #3;
      chk("rst_owner", 32'(owner), 0);
      chk("rst_terr", 32'(timeout_err), 0);
      chk("rst_sread", 32'(s_read), 0);
      chk("rst_saddr", s_address, 0);

      // reset in the middle of a stalled BUS1 transfer
      nxt; reset = 1'b1; m1_read = 1; m1_address = 32'h44; s_waitrequest = 1; #1;
      chk("t1_idle_m1_wait", 32'(m1_waitrequest), 1);
      nxt; #1;
      chk("t1_bus1_owner", 32'(owner), 2);
      chk("t1_bus1_sread", 32'(s_read), 1);
      chk("t1_bus1_saddr", s_address, 32'h44);
      nxt; reset = 1'b0; #1;
      chk("t1_rst_sread", 32'(s_read), 0);
      chk("t1_rst_swrite", 32'(s_write), 0);
      chk("t1_rst_owner", 32'(owner), 0);
      chk("t1_rst_terr", 32'(timeout_err), 0);
      m1_read = 0; s_waitrequest = 0;

      // both request after reset: m0 first, then strict alternation
      nxt; reset = 1'b1;
      m0_read = 1; m0_address = 32'h10; m1_read = 1; m1_address = 32'h14; #1;
      chk("t3_idle_owner", 32'(owner), 0);
      chk("t3_idle_m0_wait", 32'(m0_waitrequest), 1);
      chk("t3_idle_m1_wait", 32'(m1_waitrequest), 1);
      for (int k = 0; k < 4; k++) begin
         nxt;
         s_readdata = 32'h1234 + 32'(k);
         push(k[0], 1'b0, s_readdata);
         #1;
         chk("t3_owner", 32'(owner), k[0] ? 2 : 1);
         chk("t3_sread", 32'(s_read), 1);
         chk("t3_saddr", s_address, k[0] ? 32'h14 : 32'h10);
         sb_check();
      end
      nxt; m1_read = 0; s_readdata = 32'h5678; push(1'b0, 1'b0, 32'h5678); #1;
      chk("t2_owner_m0", 32'(owner), 1);
      chk("t2_m0_wait", 32'(m0_waitrequest), 0);
      sb_check();
      nxt; m0_read = 0; #1;
      chk("t2_owner_idle", 32'(owner), 0);

      // m1 write stalled 3 cycles while m0 read waits
      m1_write = 1; m1_address = 32'h20; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'b0011;
      m0_read = 1; m0_address = 32'h40; s_waitrequest = 1; #1;
      for (int i = 0; i < 3; i++) begin
         nxt; #1;
         chk("t4_owner", 32'(owner), 2);
         chk("t4_m1_wait", 32'(m1_waitrequest), 1);
         chk("t4_m0_wait", 32'(m0_waitrequest), 1);
         chk("t4_swdata", s_writedata, 32'hCAFEF00D);
         chk("t4_sbe", 32'(s_byteenable), 32'h3);
         chk("t4_swrite", 32'(s_write), 1);
      end
      nxt; s_waitrequest = 0; push(1'b1, 1'b1, 32'hCAFEF00D); #1;
      chk("t4_done_owner", 32'(owner), 2);
      chk("t4_done_m1_wait", 32'(m1_waitrequest), 0);
      sb_check();
      nxt; m1_write = 0; s_readdata = 32'hBEEF; push(1'b0, 1'b0, 32'hBEEF); #1;
      chk("t4_m0_owner", 32'(owner), 1);
      chk("t4_m0_done", 32'(m0_waitrequest), 0);
      sb_check();
      nxt; m0_read = 0; #1;
      chk("t4_idle", 32'(owner), 0);

      // watchdog: 4 stalled cycles then abort
      m0_read = 1; m0_address = 32'h50; s_waitrequest = 1; s_readdata = 32'hDEAD; #1;
      for (int i = 0; i < 4; i++) begin
         nxt; #1;
         chk("t5_stall_owner", 32'(owner), 1);
         chk("t5_stall_wait", 32'(m0_waitrequest), 1);
         chk("t5_stall_sread", 32'(s_read), 1);
      end
      nxt; push(1'b0, 1'b0, 32'h0); #1;
      chk("t5_abort_owner", 32'(owner), 1);
      chk("t5_abort_wait", 32'(m0_waitrequest), 0);
      chk("t5_abort_rdata", m0_readdata, 0);
      chk("t5_abort_sread", 32'(s_read), 0);
      chk("t5_abort_terr_pre", 32'(timeout_err), 0);
      sb_check();
      nxt; m0_read = 0; m1_read = 1; m1_address = 32'h60; s_waitrequest = 0; #1;
      chk("t5_idle_owner", 32'(owner), 0);
      chk("t5_terr_set", 32'(timeout_err), 1);
      nxt; s_readdata = 32'h77; push(1'b1, 1'b0, 32'h77); #1;
      chk("t5_m1_owner", 32'(owner), 2);
      chk("t5_m1_done", 32'(m1_waitrequest), 0);
      sb_check();
      nxt; m1_read = 0; #1;
      chk("t5_final_owner", 32'(owner), 0);
      chk("t5_terr_sticky", 32'(timeout_err), 1);

      // read and write together: treated as write
      m1_read = 1; m1_write = 1; m1_address = 32'h30; m1_writedata = 32'h12345678;
      m1_byteenable = 4'hF; #1;
      nxt; push(1'b1, 1'b1, 32'h12345678); #1;
      chk("t6_owner", 32'(owner), 2);
      chk("t6_swrite", 32'(s_write), 1);
      chk("t6_sread", 32'(s_read), 0);
      chk("t6_saddr", s_address, 32'h30);
      sb_check();
      nxt; m1_read = 0; m1_write = 0; #1;
      chk("t6_idle", 32'(owner), 0);

      chk("sb_q0_left", 32'(q0.size()), 0);
      chk("sb_q1_left", 32'(q1.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
